// File: rtl/scandbl_linebuf.sv
// Ping-pong line buffer for scan doubling. One bank captures the incoming line while
// the other replays the previous line REPEAT times.
module scandbl_linebuf #(
  parameter int unsigned   DW     = 8,
  parameter int unsigned   AW     = 10,
  parameter int unsigned   REPEAT = 2,
  parameter logic [DW-1:0] BLANK  = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cewr,
  input  logic          wren,
  input  logic          wr_eol,
  input  logic [DW-1:0] din,
  input  logic          cerd,
  input  logic          rd_sol,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic [AW:0]   line_len,
  output logic          ovf,
  output logic          underrun
);

  localparam logic [AW:0] Words  = {1'b1, {AW{1'b0}}};
  localparam logic [3:0]  RepLim = 4'(REPEAT);

  // One simple-dual-port RAM; the top address bit selects the bank.
  logic [DW-1:0] mem [2**(AW+1)];

  logic          wbank_q, wbank_d;
  logic [AW-1:0] wraddr_q, wraddr_d;
  logic [AW:0]   wcount_q, wcount_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   line_len_q, line_len_d;
  logic [3:0]    rep_cnt_q, rep_cnt_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rd_valid_q, rd_valid_d;
  logic          underrun_q, underrun_d;

  logic wr_fire, wr_full, wr_acc, swap, rd_start, rd_word;

  assign wr_fire  = cewr & wren;
  assign wr_full  = (wcount_q == Words);
  assign wr_acc   = wr_fire & ~wr_full;
  assign swap     = cewr & wr_eol;
  assign rd_start = cerd & rd_sol;
  assign rd_word  = cerd & ~rd_sol;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wbank_q, wraddr_q}] <= din;
    end
  end

  always_comb begin
    wbank_d    = wbank_q;
    wraddr_d   = wraddr_q;
    wcount_d   = wcount_q;
    ovf_d      = ovf_q;
    line_len_d = line_len_q;
    rep_cnt_d  = rep_cnt_q;
    rdaddr_d   = rdaddr_q;
    dout_d     = dout_q;
    rd_valid_d = rd_valid_q;
    underrun_d = 1'b0;

    if (wr_acc) begin
      wcount_d = wcount_q + 1'b1;
      if (wraddr_q != '1) begin
        wraddr_d = wraddr_q + 1'b1;
      end
    end
    if (wr_fire && wr_full) begin
      ovf_d = 1'b1;
    end

    // The swap latches the count including a same-cycle write into the old bank.
    if (swap) begin
      line_len_d = wcount_d;
      wbank_d    = ~wbank_q;
      wraddr_d   = '0;
      wcount_d   = '0;
      ovf_d      = 1'b0;
      rep_cnt_d  = '0;
    end

    if (rd_start) begin
      rdaddr_d   = '0;
      dout_d     = BLANK;
      rd_valid_d = 1'b0;
      if (swap) begin
        rep_cnt_d = 4'd1;
      end else begin
        underrun_d = (rep_cnt_q >= RepLim);
        if (rep_cnt_q != 4'hf) begin
          rep_cnt_d = rep_cnt_q + 4'd1;
        end
      end
    end else if (rd_word) begin
      if ({1'b0, rdaddr_q} < line_len_q) begin
        dout_d     = mem[{~wbank_q, rdaddr_q}];
        rd_valid_d = 1'b1;
      end else begin
        dout_d     = BLANK;
        rd_valid_d = 1'b0;
      end
      if (rdaddr_q != '1) begin
        rdaddr_d = rdaddr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbank_q    <= 1'b0;
      wraddr_q   <= '0;
      wcount_q   <= '0;
      ovf_q      <= 1'b0;
      line_len_q <= '0;
      rep_cnt_q  <= '0;
      rdaddr_q   <= '0;
      dout_q     <= BLANK;
      rd_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wbank_q    <= wbank_d;
      wraddr_q   <= wraddr_d;
      wcount_q   <= wcount_d;
      ovf_q      <= ovf_d;
      line_len_q <= line_len_d;
      rep_cnt_q  <= rep_cnt_d;
      rdaddr_q   <= rdaddr_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;
  assign line_len = line_len_q;
  assign ovf      = ovf_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_scandbl_linebuf.sv
// Bench for scandbl_linebuf: directed scenarios then random traffic, checked against a
// queue-based model of captured and replayed lines.
module tb_scandbl_linebuf;

  localparam int unsigned   DW     = 8;
  localparam int unsigned   AW     = 4;
  localparam int unsigned   REPEAT = 2;
  localparam logic [DW-1:0] BLANK  = 8'hA5;
  localparam int            W      = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cewr, wren, wr_eol, cerd, rd_sol;
  logic [DW-1:0] din, dout;
  logic          rd_valid, ovf, underrun;
  logic [AW:0]   line_len;

  always #5 clk = ~clk;

  scandbl_linebuf #(
    .DW     (DW),
    .AW     (AW),
    .REPEAT (REPEAT),
    .BLANK  (BLANK)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cewr     (cewr),
    .wren     (wren),
    .wr_eol   (wr_eol),
    .din      (din),
    .cerd     (cerd),
    .rd_sol   (rd_sol),
    .dout     (dout),
    .rd_valid (rd_valid),
    .line_len (line_len),
    .ovf      (ovf),
    .underrun (underrun)
  );

  int compared = 0;
  int mismatched = 0;

  // Model: the line being captured, the line being replayed, replay position and count.
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  bit            m_ovf, m_valid, m_under;
  int            m_rep, m_idx;
  logic [DW-1:0] m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"}, 32'(dout), 32'(m_dout));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_valid));
    check({tag, ".line_len"}, 32'(line_len), rq.size());
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, ".underrun"}, 32'(underrun), 32'(m_under));
  endtask

  task automatic model_reset();
    wq.delete();
    rq.delete();
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_under = 1'b0;
    m_rep   = 0;
    m_idx   = 0;
    m_dout  = BLANK;
  endtask

  // Order of effects: write, word read on the old line, line swap, then line start.
  task automatic model_step();
    bit swapped = 1'b0;
    m_under = 1'b0;
    if (cewr && wren) begin
      if (wq.size() < W) wq.push_back(din);
      else m_ovf = 1'b1;
    end
    if (cerd && !rd_sol) begin
      if (m_idx < rq.size()) begin
        m_dout  = rq[m_idx];
        m_valid = 1'b1;
      end else begin
        m_dout  = BLANK;
        m_valid = 1'b0;
      end
      if (m_idx < W - 1) m_idx++;
    end
    if (cewr && wr_eol) begin
      rq = wq;
      wq.delete();
      m_ovf   = 1'b0;
      m_rep   = 0;
      swapped = 1'b1;
    end
    if (cerd && rd_sol) begin
      m_idx   = 0;
      m_dout  = BLANK;
      m_valid = 1'b0;
      if (swapped) begin
        m_rep = 1;
      end else begin
        m_under = (m_rep >= int'(REPEAT));
        if (m_rep < 15) m_rep++;
      end
    end
  endtask

  task automatic step(input bit i_cewr, input bit i_wren, input bit i_eol,
                      input logic [DW-1:0] i_din, input bit i_cerd, input bit i_sol,
                      input string tag);
    cewr   = i_cewr;
    wren   = i_wren;
    wr_eol = i_eol;
    din    = i_din;
    cerd   = i_cerd;
    rd_sol = i_sol;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b0, d, 1'b0, 1'b0, "wr");
  endtask

  task automatic eol();
    step(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, "eol");
  endtask

  task automatic sol(input string tag);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, tag);
  endtask

  task automatic rd(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    reset_n = 1'b0;
    cewr = 1'b0; wren = 1'b0; wr_eol = 1'b0; din = '0; cerd = 1'b0; rd_sol = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic replay of a full-length line, with a disabled write and read mixed in.
    for (int i = 0; i < W; i++) begin
      wr(8'(8'h10 + i));
      if (i == 5) step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, "gated_wr");
    end
    eol();
    check("basic.len16", 32'(line_len), 32'd16);
    sol("basic.sol");
    rd(3, "basic.rd");
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "basic.hold");
    rd(W - 3, "basic.rd");
    check("basic.last", 32'(dout), 32'h1F);
    rd(2, "basic.sat");

    // Doubling: two clean replays, underrun only on the third line start.
    for (int i = 0; i < 5; i++) wr(8'($urandom));
    eol();
    sol("dbl.sol1");
    rd(6, "dbl.rd1");
    sol("dbl.sol2");
    check("dbl.no_under", 32'(underrun), 32'd0);
    rd(6, "dbl.rd2");
    sol("dbl.sol3");
    check("dbl.under", 32'(underrun), 32'd1);
    rd(2, "dbl.rd3");

    // Short line: reads past its end give BLANK.
    for (int i = 0; i < 4; i++) wr(8'($urandom));
    eol();
    sol("short.sol");
    rd(8, "short.rd");
    check("short.blank", 32'(dout), 32'(BLANK));

    // Overflow: two writes beyond capacity, then the sticky flag clears on the swap.
    for (int i = 0; i < W + 2; i++) wr(8'($urandom));
    check("ovf.set", 32'(ovf), 32'd1);
    eol();
    check("ovf.clr", 32'(ovf), 32'd0);
    sol("ovf.sol");
    rd(W + 2, "ovf.rd");

    // Collision: write, end of line and start of line in one cycle.
    for (int i = 0; i < 3; i++) wr(8'($urandom));
    step(1'b1, 1'b1, 1'b1, 8'h5C, 1'b1, 1'b1, "coll");
    check("coll.len", 32'(line_len), 32'd4);
    rd(5, "coll.rd");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0), 8'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0), "rand");
    end

    // Reset mid-read takes effect without a clock edge.
    for (int i = 0; i < 6; i++) wr(8'($urandom));
    eol();
    sol("pre_rst.sol");
    rd(3, "pre_rst.rd");
    cewr = 1'b0; wren = 1'b0; wr_eol = 1'b0; cerd = 1'b0; rd_sol = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    sol("post_rst.sol");
    rd(4, "post_rst.rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
